// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - DMA channel arbiter acquiring the processor bus via hold/hlda
// Arbitrates among NCH request channels, one bus tenure at a time, with fixed or rotating priority.
module dma_bus_arbiter #(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 8,
  parameter int ROTATE    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] dreq,
  input  logic [NCH-1:0] mask,
  input  logic           hlda,
  input  logic           cycle_done,
  output logic           hold,
  output logic [NCH-1:0] dack,
  output logic           busy,
  output logic [2:0]     cur_ch,
  output logic           abort
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  state_t         state;
  logic [7:0]     burst_cnt;
  logic [2:0]     last_ch;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] elig_shift;
  logic           cur_live;
  logic [2:0]     winner;
  logic [7:0]     cnt_inc;
  logic           burst_end;

  assign elig       = dreq & ~mask;
  assign elig_shift = elig >> cur_ch;
  assign cur_live   = elig_shift[0];

  // Search starts just past the last served channel when rotating, else at channel 0.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (ROTATE != 0) ? ((int'(last_ch) + 1 + i) % NCH) : i;
      if (!found && elig[idx]) begin
        winner = idx[2:0];
        found  = 1'b1;
      end
    end
  end

  // Saturating count; a transfer coinciding with the channel dropping still counts.
  assign cnt_inc   = (cycle_done && burst_cnt != 8'hFF) ? burst_cnt + 8'd1 : burst_cnt;
  assign burst_end = (cnt_inc >= 8'(MAX_BURST)) || !cur_live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= 1'b0;
      dack      <= '0;
      busy      <= 1'b0;
      cur_ch    <= '0;
      abort     <= 1'b0;
      burst_cnt <= '0;
      last_ch   <= 3'(NCH - 1);
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (elig != '0 && !hlda) begin
            cur_ch    <= winner;
            burst_cnt <= '0;
            hold      <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (!cur_live) begin
            hold  <= 1'b0;
            state <= RELEASE;
          end else if (hlda) begin
            dack  <= ONE_HOT0 << cur_ch;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!hlda) begin
            dack  <= '0;
            hold  <= 1'b0;
            abort <= 1'b1;
            state <= RELEASE;
          end else begin
            burst_cnt <= cnt_inc;
            if (burst_end) begin
              dack  <= '0;
              hold  <= 1'b0;
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          hold    <= 1'b0;
          dack    <= '0;
          last_ch <= cur_ch;
          if (!hlda) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of DMA request channels (2..8).
REQ-002 Parameter MAX_BURST, default 8, maximum byte transfers per bus tenure (1..255).
REQ-003 Parameter ROTATE, default 1; 1 selects rotating priority, 0 selects fixed priority with channel 0 highest.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 dreq  input  NCH  per-channel DMA request, level, active high.
REQ-008 mask  input  NCH  per-channel disable; masked channels are never granted.
REQ-009 hlda  input  1  hold acknowledge from processor.
REQ-010 cycle_done  input  1  one-cycle pulse marking completion of one DMA byte transfer.
REQ-011 hold  output  1  bus request to processor.
REQ-012 dack  output  NCH  one-hot channel acknowledge, active high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 cur_ch  output  3  index of latched channel, valid while busy.
REQ-015 abort  output  1  one-cycle pulse when tenure is revoked by processor.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states SHALL be IDLE, REQ, GRANT, RELEASE.
REQ-018 Eligible set = dreq & ~mask.
REQ-019 IDLE: if eligible set nonzero, latch winner into cur_ch, clear burst counter, assert hold, go REQ (hold high the cycle after dreq is sampled).
REQ-020 Winner, ROTATE=0: lowest eligible index.
REQ-021 Winner, ROTATE=1: first eligible index searching upward, with wrap, from (last served channel + 1) mod NCH; after reset last served = NCH-1, so channel 0 searched first.
REQ-022 REQ: hold stays high; dack stays zero; on hlda=1 go GRANT and assert dack[cur_ch] next cycle.
REQ-023 REQ: if dreq[cur_ch] drops or mask[cur_ch] rises before hlda, go RELEASE (no dack issued).
REQ-024 GRANT: each cycle_done increments 8-bit burst counter; counter never wraps.
REQ-025 GRANT exit to RELEASE when any of: counter reaches MAX_BURST after increment; dreq[cur_ch]=0; mask[cur_ch]=1.
REQ-026 cycle_done coinciding with dreq[cur_ch] falling SHALL count that transfer, then exit.
REQ-027 cycle_done outside GRANT SHALL be ignored.
REQ-028 GRANT: if hlda=0, clear dack and hold, pulse abort one cycle, go RELEASE.
REQ-029 RELEASE: hold=0, dack=0; update last served = cur_ch; go IDLE when hlda=0.
REQ-030 IDLE SHALL NOT re-request while hlda=1.
REQ-031 dack SHALL be one-hot or zero at all times; dack nonzero implies hold=1 and hlda observed high.
REQ-032 Changes to dreq of non-latched channels SHALL not affect an active tenure.

Reset
REQ-033 On rst high, immediately: state IDLE, hold=0, dack=0, busy=0, cur_ch=0, abort=0, burst counter=0, last served=NCH-1.
REQ-034 Reset asserted mid-tenure SHALL drop hold and dack asynchronously, with no abort pulse.
REQ-035 After rst release, first request arbitration occurs on the first rising clk edge with eligible dreq.

Verification
REQ-036 dreq=4'b0010, hlda rises 2 cycles after hold, 3 cycle_done pulses, then dreq drops -> dack=4'b0010 for the tenure, hold falls, IDLE after hlda=0.
REQ-037 ROTATE=1, dreq=4'b1111 held, MAX_BURST=2 -> tenures granted in order ch0, ch1, ch2, ch3, ch0, each ending after 2 cycle_done.
REQ-038 ROTATE=0, dreq=4'b1010, mask=4'b0010 -> ch3 granted; mask cleared -> next tenure ch1.
REQ-039 hlda dropped during GRANT -> dack=0 and hold=0 next cycle, abort high exactly one cycle.
REQ-040 rst pulsed while dack=4'b0100 -> hold=0, dack=0 before next clk edge; abort stays 0.
REQ-041 dreq[cur_ch] falls in same cycle as cycle_done with counter=5 -> counter=6, RELEASE next cycle.
